// File: rtl/kf_pkg.sv
// Shared defaults, FSM encoding and helpers for the KF frame sequencer slice.
package kf_pkg;

  localparam int KF_N       = 20;
  localparam int KF_FRAC    = 10;
  localparam int KF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } kf_state_e;

  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/kf_frame_timer.sv
// Frame watchdog: counts WAIT cycles, flags the timeout cycle, captures saturated latency.
// Latency: timeout/latency are combinational on the current count; lat is registered on cap.
// Backpressure: none; driven purely by the sequencer FSM.
module kf_frame_timer
  import kf_pkg::*;
#(
  parameter int TIMEOUT = KF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic       cap,
  output logic       timeout,
  output logic [7:0] lat
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cur;

  // cur is the count of the cycle in progress, so the first WAIT cycle reads 1
  assign cur     = cnt + CW'(1);
  assign timeout = inc & (cur == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      lat <= '0;
    end else begin
      if (clr)      cnt <= '0;
      else if (inc) cnt <= cur;
      if (cap)      lat <= sat8(32'(cur));
    end
  end

endmodule

// File: rtl/kf_frame_sequencer.sv
// Closed-loop frame controller for top_kf: sample in, start/done handshake, X_post fed back.
// Latency: sample transfer to est_valid is 3 + core latency cycles; one frame in flight.
// Backpressure: s_ready only in IDLE with enable and no init; watchdog aborts a stuck core.
module kf_frame_sequencer
  import kf_pkg::*;
#(
  parameter int N       = KF_N,
  parameter int FRAC    = KF_FRAC,
  parameter int TIMEOUT = KF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         init,
  input  logic [N-1:0] x0_init,
  input  logic [N-1:0] x1_init,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] s_u0,
  input  logic [N-1:0] s_u1,
  input  logic [N-1:0] s_z0,
  input  logic [N-1:0] s_z1,
  output logic         kf_start,
  input  logic         kf_done,
  output logic [N-1:0] kf_x0_prev,
  output logic [N-1:0] kf_x1_prev,
  output logic [N-1:0] kf_u0,
  output logic [N-1:0] kf_u1,
  output logic [N-1:0] kf_z0,
  output logic [N-1:0] kf_z1,
  input  logic [N-1:0] kf_x0_post,
  input  logic [N-1:0] kf_x1_post,
  output logic         est_valid,
  output logic [N-1:0] est_x0,
  output logic [N-1:0] est_x1,
  output logic         busy,
  output logic [31:0]  frame_cnt,
  output logic [7:0]   last_lat,
  output logic         timeout_err
);

  if (FRAC >= N || TIMEOUT < 2) begin : g_param_check
    $error("kf_frame_sequencer: FRAC must be < N and TIMEOUT >= 2");
  end

  kf_state_e     st;
  logic [N-1:0]  x0, x1;
  logic          rdy_en;
  logic          xfer;
  logic          tmo;
  logic [7:0]    lat;

  // rdy_en keeps s_ready low through reset and the first edge after release
  assign s_ready    = rdy_en & (st == ST_IDLE) & enable & ~init;
  assign xfer       = s_valid & s_ready;
  assign busy       = (st != ST_IDLE);
  assign kf_x0_prev = x0;
  assign kf_x1_prev = x1;
  assign est_x0     = x0;
  assign est_x1     = x1;

  kf_frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (st == ST_LAUNCH),
    .inc     (st == ST_WAIT),
    .cap     ((st == ST_WAIT) & kf_done),
    .timeout (tmo),
    .lat     (lat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= ST_IDLE;
      x0          <= '0;
      x1          <= '0;
      kf_u0       <= '0;
      kf_u1       <= '0;
      kf_z0       <= '0;
      kf_z1       <= '0;
      kf_start    <= 1'b0;
      est_valid   <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
      last_lat    <= '0;
      rdy_en      <= 1'b0;
    end else begin
      rdy_en    <= 1'b1;
      kf_start  <= 1'b0;
      est_valid <= 1'b0;
      if (init) begin
        // core keeps running; whatever it returns later is dropped in IDLE
        st          <= ST_IDLE;
        x0          <= x0_init;
        x1          <= x1_init;
        timeout_err <= 1'b0;
      end else begin
        case (st)
          ST_IDLE: begin
            if (xfer) begin
              kf_u0    <= s_u0;
              kf_u1    <= s_u1;
              kf_z0    <= s_z0;
              kf_z1    <= s_z1;
              kf_start <= 1'b1;
              st       <= ST_LAUNCH;
            end
          end
          ST_LAUNCH: st <= ST_WAIT;
          ST_WAIT: begin
            if (kf_done) begin
              st <= ST_COMMIT;
            end else if (tmo) begin
              timeout_err <= 1'b1;
              st          <= ST_IDLE;
            end
          end
          ST_COMMIT: begin
            x0        <= kf_x0_post;
            x1        <= kf_x1_post;
            est_valid <= 1'b1;
            frame_cnt <= frame_cnt + 32'd1;
            last_lat  <= lat;
            st        <= ST_IDLE;
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
